// File: rtl/key_debouncer.sv
// key_debouncer: per-key two-flop synchroniser, stability-counter debouncer and
// registered press/release pulse generator for active-low pushbuttons.
// Optional auto-repeat of press pulses while a key is held: define KEY_REPEAT_EN.
module key_debouncer #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W    = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RR_LAST = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;
`endif

  // Counters below rely on a terminal count of at least 1.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_params
    $error("key_debouncer: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 2");
  end

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] pressed_sync;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_sync = ~sync2_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            stable_q;
    logic            stable_d;
    logic            accept_c;
    logic            press_edge_c;
    logic            release_edge_c;
    logic            rpt_fire_c;
    logic            press_q;
    logic            release_q;

    // Debounce next state: count consecutive disagreements, accept at terminal count.
    always_comb begin
      db_cnt_d = db_cnt_q;
      stable_d = stable_q;
      accept_c = 1'b0;
      if (pressed_sync[k] == stable_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        accept_c = 1'b1;
        stable_d = pressed_sync[k];
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    assign press_edge_c   = accept_c &  pressed_sync[k];
    assign release_edge_c = accept_c & ~pressed_sync[k];

`ifdef KEY_REPEAT_EN
    rpt_state_e       rpt_state_q;
    logic [RPT_W-1:0] rpt_cnt_q;

    // A release overrides a repeat that falls due on the same cycle.
    assign rpt_fire_c = ~release_edge_c &
                        (((rpt_state_q == DELAY)  && (rpt_cnt_q == RD_LAST)) ||
                         ((rpt_state_q == REPEAT) && (rpt_cnt_q == RR_LAST)));

    // Auto-repeat FSM: initial hold delay, then periodic repeats until release.
    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        rpt_state_q <= IDLE;
        rpt_cnt_q   <= '0;
      end else if (release_edge_c) begin
        rpt_state_q <= IDLE;
        rpt_cnt_q   <= '0;
      end else begin
        case (rpt_state_q)
          IDLE: begin
            if (press_edge_c) begin
              rpt_state_q <= DELAY;
              rpt_cnt_q   <= '0;
            end
          end
          DELAY: begin
            if (rpt_cnt_q == RD_LAST) begin
              rpt_state_q <= REPEAT;
              rpt_cnt_q   <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt_q == RR_LAST) begin
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
          end
          default: begin
            rpt_state_q <= IDLE;
            rpt_cnt_q   <= '0;
          end
        endcase
      end
    end
`else
    assign rpt_fire_c = 1'b0;
`endif

    // Debounce state and registered one-cycle pulses.
    always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
        db_cnt_q  <= '0;
        stable_q  <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        stable_q  <= stable_d;
        press_q   <= press_edge_c | rpt_fire_c;
        release_q <= release_edge_c;
      end
    end

    assign key_level[k]   = stable_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: history-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_key_debouncer;

  localparam int NK   = 4;
  localparam int DC   = 8;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int MAXE = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [NK-1:0] level;
  logic [NK-1:0] press;
  logic [NK-1:0] key_rel;

  always #5 clk = ~clk;

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .KEY        (key),
    .key_level  (level),
    .key_press  (press),
    .key_release(key_rel)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: remembers every sampled input and reset, and derives the
  // outputs from "value seen by the debouncer was constant for DC samples since
  // the last acceptance or reset".
  int            cyc = 0;
  bit            rst_h  [MAXE];
  logic [NK-1:0] raw_h  [MAXE];
  logic [NK-1:0] seen_h [MAXE];
  int            barrier[NK];
  int            hold_t [NK];
  logic [NK-1:0] m_stable;
  logic [NK-1:0] exp_level;
  logic [NK-1:0] exp_press;
  logic [NK-1:0] exp_rel;
  bit            model_valid = 1'b0;
  bit            mv;
  bit            steady;
  bit            accepted;
  int            d;

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_h[cyc] = rst;
    raw_h[cyc] = ~key;
    if (cyc < 3) seen_h[cyc] = '0;
    else if (rst_h[cyc-1] || rst_h[cyc-2]) seen_h[cyc] = '0;
    else seen_h[cyc] = raw_h[cyc-2];
    exp_press = '0;
    exp_rel   = '0;
    if (rst) begin
      m_stable    = '0;
      model_valid = 1'b1;
      for (int k = 0; k < NK; k++) begin
        barrier[k] = cyc;
        hold_t[k]  = -1;
      end
    end else if (model_valid) begin
      for (int k = 0; k < NK; k++) begin
        mv       = seen_h[cyc][k];
        accepted = 1'b0;
        if (mv != m_stable[k] && barrier[k] <= cyc - DC) begin
          steady = 1'b1;
          for (int j = cyc - DC + 1; j <= cyc; j++)
            if (seen_h[j][k] != mv) steady = 1'b0;
          if (steady) begin
            accepted    = 1'b1;
            m_stable[k] = mv;
            barrier[k]  = cyc;
            if (mv) begin
              exp_press[k] = 1'b1;
              hold_t[k]    = cyc;
            end else begin
              exp_rel[k] = 1'b1;
              hold_t[k]  = -1;
            end
          end
        end
`ifdef KEY_REPEAT_EN
        if (!accepted && m_stable[k] && hold_t[k] >= 0) begin
          d = cyc - hold_t[k];
          if (d == RD || (d > RD && ((d - RD) % RR) == 0)) exp_press[k] = 1'b1;
        end
`endif
      end
    end
    exp_level = m_stable;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_level",   32'(level),   32'(exp_level));
      chk("cyc_press",   32'(press),   32'(exp_press));
      chk("cyc_release", 32'(key_rel), 32'(exp_rel));
    end
  end

  int pc;

  initial begin
    // Reset held for three edges with all keys released.
    rst = 1'b1;
    key = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_level",   32'(level),   32'h0);
    chk("rst_press",   32'(press),   32'h0);
    chk("rst_release", 32'(key_rel), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_level", 32'(level), 32'h0);

    // Key 0 press: accepted at edge 10, single-cycle pulse.
    key[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("k0_pre_level", 32'(level), 32'h0);
    chk("k0_pre_press", 32'(press), 32'h0);
    @(negedge clk);
    chk("k0_level", 32'(level), 32'h1);
    chk("k0_press", 32'(press), 32'h1);
    @(negedge clk);
    chk("k0_press_width", 32'(press), 32'h0);

    // Key 0 release: accepted at edge 10 after the release.
    key[0] = 1'b1;
    repeat (9) @(negedge clk);
    chk("k0_rel_pre_level", 32'(level),   32'h1);
    chk("k0_rel_pre",       32'(key_rel), 32'h0);
    @(negedge clk);
    chk("k0_rel_level", 32'(level),   32'h0);
    chk("k0_release",   32'(key_rel), 32'h1);
    @(negedge clk);
    chk("k0_rel_width", 32'(key_rel), 32'h0);

    // Key 1 bounce: 3-cycle runs never qualify; final hold gives one press.
    pc = 0;
    for (int i = 0; i < 10; i++) begin
      key[1] = ~key[1];
      repeat (3) begin
        @(negedge clk);
        pc += int'(press[1]);
      end
    end
    chk("k1_bounce_quiet", 32'(pc), 32'h0);
    key[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      pc += int'(press[1]);
    end
    chk("k1_press",       32'(press), 32'h2);
    chk("k1_press_count", 32'(pc),    32'h1);
    key[1] = 1'b1;
    repeat (12) @(negedge clk);
    chk("k1_released", 32'(level), 32'h0);

    // Key 2 held: repeats at T+20, T+25, ...; release at T+35 beats the repeat due then.
    key[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("k2_press_T", 32'(press), 32'h4);
    repeat (19) @(negedge clk);
    chk("k2_T19", 32'(press), 32'h0);
    @(negedge clk);
`ifdef KEY_REPEAT_EN
    chk("k2_T20", 32'(press), 32'h4);
`else
    chk("k2_T20", 32'(press), 32'h0);
`endif
    repeat (5) @(negedge clk);
`ifdef KEY_REPEAT_EN
    chk("k2_T25", 32'(press), 32'h4);
`else
    chk("k2_T25", 32'(press), 32'h0);
`endif
    key[2] = 1'b1;
    repeat (10) @(negedge clk);
    chk("k2_release_T35", 32'(key_rel), 32'h4);
    chk("k2_nopress_T35", 32'(press),   32'h0);
    pc = 0;
    repeat (30) begin
      @(negedge clk);
      pc += int'(press[2]);
    end
    chk("k2_quiet_after_release", 32'(pc), 32'h0);

    // Key 3: reset interrupts debounce at count 5; fresh press after reset.
    key[3] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("k3_rst_press", 32'(press), 32'h0);
    chk("k3_rst_level", 32'(level), 32'h0);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    chk("k3_pre_press", 32'(press), 32'h0);
    @(negedge clk);
    chk("k3_press", 32'(press), 32'h8);
    chk("k3_level", 32'(level), 32'h8);
    @(negedge clk);
    chk("k3_press_width", 32'(press), 32'h0);
    key[3] = 1'b1;
    repeat (12) @(negedge clk);
    chk("final_level", 32'(level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
